// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO with a registered output stage feeding alu_top
module alu_cmd_queue #(
  parameter int N = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_operation,
  input  logic [N-1:0]             cmd_operand1,
  input  logic [N-1:0]             cmd_operand2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               operation,
  output logic [N-1:0]             operand1,
  output logic [N-1:0]             operand2,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [2*N+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign cmd_ready = (level < LW'(DEPTH)) && !flush && !reset;
  assign push = cmd_valid && cmd_ready;
  // head moves into the output register whenever that register is free or being consumed
  assign pop = (level != '0) && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_operation, cmd_operand1, cmd_operand2};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      operation <= '0;
      operand1  <= '0;
      operand2  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {operation, operand1, operand2} <= mem[rd_ptr];
      end
      level     <= level + LW'(push) - LW'(pop);
      out_valid <= pop || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: vector table, directed corner sequences and a queue-based reference model
module tb_alu_cmd_queue;
  localparam int N = 8;
  localparam int DEPTH = 4;
  logic clk, reset, flush, cmd_valid, cmd_ready, out_valid, out_ready;
  logic [1:0] cmd_operation, operation;
  logic [N-1:0] cmd_operand1, cmd_operand2, operand1, operand2;
  logic [$clog2(DEPTH):0] level;
  int n_chk = 0, n_fail = 0;

  alu_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_operation(cmd_operation), .cmd_operand1(cmd_operand1), .cmd_operand2(cmd_operand2),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .operand1(operand1), .operand2(operand2), .level(level)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct packed { logic [1:0] op; logic [N-1:0] a; logic [N-1:0] b; } cmd_t;
  cmd_t q[$];
  bit m_v;
  cmd_t m_out;

  function automatic bit m_ready(bit r, bit f);
    return !r && !f && (q.size() < DEPTH);
  endfunction

  task automatic m_edge(input bit r, f, v, rdy, input cmd_t c);
    bit acc;
    if (r) begin
      q.delete(); m_v = 0; m_out = '0;
    end else if (f) begin
      q.delete(); m_v = 0;
    end else begin
      acc = v && m_ready(r, f);
      if (q.size() > 0 && (!m_v || rdy)) begin
        m_out = q.pop_front(); m_v = 1;
      end else if (m_v && rdy) m_v = 0;
      if (acc) q.push_back(c);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_cmp();
    chk("model out_valid", 32'(out_valid), 32'(m_v));
    chk("model level", 32'(level), 32'(q.size()));
    chk("model operation", 32'(operation), 32'(m_out.op));
    chk("model operand1", 32'(operand1), 32'(m_out.a));
    chk("model operand2", 32'(operand2), 32'(m_out.b));
  endtask

  task automatic cyc(input bit r, f, v, rdy, input logic [1:0] op, input logic [N-1:0] a, b,
                     output bit rdy_seen);
    bit exp_rdy;
    reset = r; flush = f; cmd_valid = v; out_ready = rdy;
    cmd_operation = op; cmd_operand1 = a; cmd_operand2 = b;
    @(negedge clk);
    rdy_seen = cmd_ready;
    exp_rdy = m_ready(r, f);
    chk("model cmd_ready", 32'(rdy_seen), 32'(exp_rdy));
    @(posedge clk);
    m_edge(r, f, v, rdy, '{op: op, a: a, b: b});
    #1;
    m_cmp();
  endtask

  typedef struct {
    bit v; bit rdy; logic [1:0] op; logic [N-1:0] a; logic [N-1:0] b;
    bit erdy; bit ev; logic [1:0] eop; logic [N-1:0] ea; logic [N-1:0] eb; int elev;
  } tv_t;
  tv_t tv[14];

  initial begin
    bit rs;
    tv = '{
      '{1, 1, 1, 3, 5,   1, 0, 0, 0, 0,  1},
      '{0, 1, 0, 0, 0,   1, 1, 1, 3, 5,  0},
      '{0, 1, 0, 0, 0,   1, 0, 1, 3, 5,  0},
      '{1, 0, 2, 1, 9,   1, 0, 1, 3, 5,  1},
      '{1, 0, 2, 2, 10,  1, 1, 2, 1, 9,  1},
      '{1, 0, 2, 3, 11,  1, 1, 2, 1, 9,  2},
      '{1, 0, 2, 4, 12,  1, 1, 2, 1, 9,  3},
      '{1, 0, 2, 5, 13,  1, 1, 2, 1, 9,  4},
      '{1, 0, 3, 6, 14,  0, 1, 2, 1, 9,  4},
      '{0, 1, 0, 0, 0,   0, 1, 2, 2, 10, 3},
      '{0, 1, 0, 0, 0,   1, 1, 2, 3, 11, 2},
      '{0, 1, 0, 0, 0,   1, 1, 2, 4, 12, 1},
      '{0, 1, 0, 0, 0,   1, 1, 2, 5, 13, 0},
      '{0, 1, 0, 0, 0,   1, 0, 2, 5, 13, 0}
    };
    m_v = 0; m_out = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, rs);
    cyc(1, 0, 1, 0, 0, 0, 0, rs);
    chk("reset cmd_ready", 32'(rs), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset level", 32'(level), 0);

    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, tv[i].v, tv[i].rdy, tv[i].op, tv[i].a, tv[i].b, rs);
      chk($sformatf("vec%0d cmd_ready", i), 32'(rs), 32'(tv[i].erdy));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d operation", i), 32'(operation), 32'(tv[i].eop));
      chk($sformatf("vec%0d operand1", i), 32'(operand1), 32'(tv[i].ea));
      chk($sformatf("vec%0d operand2", i), 32'(operand2), 32'(tv[i].eb));
      chk($sformatf("vec%0d level", i), 32'(level), tv[i].elev);
    end

    // streaming: one in FIFO, one presented, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1, 2'(i % 4), N'(i), N'(255 - i), rs);
      if (i >= 1) begin
        chk("stream out_valid", 32'(out_valid), 1);
        chk("stream level", 32'(level), 1);
        chk("stream operand1", 32'(operand1), i - 1);
      end
    end
    cyc(0, 0, 0, 1, 0, 0, 0, rs);
    chk("stream tail operand1", 32'(operand1), 19);
    cyc(0, 0, 0, 1, 0, 0, 0, rs);
    chk("stream drained", 32'(out_valid), 0);

    // flush with a concurrent push
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, N'(8'hA0 + i), N'(i), rs);
    chk("preflush level", 32'(level), 3);
    chk("preflush operand1", 32'(operand1), 32'h A0);
    cyc(0, 1, 1, 1, 3, N'(8'hEE), N'(8'hEE), rs);
    chk("flush cmd_ready", 32'(rs), 0);
    chk("flush level", 32'(level), 0);
    chk("flush out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0, rs);
      chk("postflush out_valid", 32'(out_valid), 0);
      chk("postflush no EE", 32'(operand1 == N'(8'hEE)), 0);
    end

    // reset mid-stream with level 2 and a presented command
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 2, N'(8'h30 + i), N'(8'h40 + i), rs);
    chk("prereset level", 32'(level), 2);
    chk("prereset out_valid", 32'(out_valid), 1);
    cyc(1, 0, 1, 1, 1, 7, 7, rs);
    chk("midreset cmd_ready", 32'(rs), 0);
    chk("midreset level", 32'(level), 0);
    chk("midreset outputs", 32'({out_valid, operation, operand1, operand2}), 0);
    cyc(0, 0, 0, 1, 0, 0, 0, rs);
    chk("release cmd_ready", 32'(rs), 1);
    cyc(0, 0, 0, 1, 0, 0, 0, rs);
    chk("release out_valid", 32'(out_valid), 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1, 2'($urandom), N'($urandom), N'($urandom), rs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
